// File: rtl/output_requant_pkg.sv
// output_requant_pkg: shared FSM encoding, pipeline depth, output width and clamp limits
package output_requant_pkg;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam int STREAM_DATA_WIDTH = 8;
   localparam int PIPE_DEPTH = 3;
   localparam int RELU_MAX = 255;
   localparam int SAT_MAX = 127;
   localparam int SAT_MIN = -128;
   typedef struct packed {
      logic [9:0] layers;
      logic [9:0] rows;
      logic [9:0] cols;
   } dims_t;
endpackage

// File: rtl/output_requant_if.sv
// output_requant_if: accumulator stream in, output FIFO write port out
interface output_requant_if #(
   parameter int ACC_WIDTH = 32,
   parameter int STREAM_DATA_WIDTH = 8,
   parameter int FIFO_COUNT_WIDTH = 10
);
   logic signed [ACC_WIDTH-1:0] acc_data;
   logic acc_valid;
   logic acc_ready;
   logic [STREAM_DATA_WIDTH-1:0] fifo_din;
   logic fifo_wr_en;
   logic [FIFO_COUNT_WIDTH-1:0] fifo_dcount;
   modport slave (input acc_data, acc_valid, fifo_dcount, output acc_ready, fifo_din, fifo_wr_en);
   modport master (output acc_data, acc_valid, fifo_dcount, input acc_ready, fifo_din, fifo_wr_en);
endinterface

// File: rtl/output_requant_pipe.sv
// requant_pipe: three-stage bias add, round-half-up arithmetic shift, and ReLU/signed clamp
module requant_pipe import output_requant_pkg::*; #(
   parameter int ACC_WIDTH = 32,
   parameter int DATA_W = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid_i,
   input  logic signed [ACC_WIDTH-1:0] acc_i,
   input  logic signed [ACC_WIDTH-1:0] bias_i,
   input  logic [4:0] shift_i,
   input  logic relu_i,
   output logic [PIPE_DEPTH-1:0] vld_o,
   output logic [DATA_W-1:0] dout_o
);
   localparam int W = ACC_WIDTH + 2;
   logic signed [ACC_WIDTH:0] sum_q;
   logic signed [W-1:0] rnd_q, rnd_d, half, sat;
   logic [PIPE_DEPTH-1:0] vld_q;
   logic [DATA_W-1:0] dout_q;
   // two guard bits keep the rounding add from overflowing the 33-bit sum
   always_comb begin
      half = shift_i == 5'd0 ? '0 : W'(1) <<< (shift_i - 5'd1);
      rnd_d = ($signed({sum_q[ACC_WIDTH], sum_q}) + half) >>> shift_i;
      sat = relu_i ? (rnd_q[W-1] ? '0 : rnd_q > W'(RELU_MAX) ? W'(RELU_MAX) : rnd_q)
                   : (rnd_q < W'(SAT_MIN) ? W'(SAT_MIN) : rnd_q > W'(SAT_MAX) ? W'(SAT_MAX) : rnd_q);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         sum_q <= '0;
         rnd_q <= '0;
         dout_q <= '0;
      end else begin
         vld_q <= {vld_q[PIPE_DEPTH-2:0], in_valid_i};
         if (in_valid_i) sum_q <= {acc_i[ACC_WIDTH-1], acc_i} + {bias_i[ACC_WIDTH-1], bias_i};
         if (vld_q[0]) rnd_q <= rnd_d;
         if (vld_q[1]) dout_q <= sat[DATA_W-1:0];
      end
   end
   assign vld_o = vld_q;
   assign dout_o = dout_q;
endmodule

// File: rtl/output_requant.sv
// output_requant: layer-set FSM, col/row/layer counters and FIFO high-water flow control
// around the requant_pipe arithmetic.
module output_requant #(
   parameter int ACC_WIDTH = 32,
   parameter int STREAM_DATA_WIDTH = output_requant_pkg::STREAM_DATA_WIDTH,
   parameter int FIFO_COUNT_WIDTH = 10,
   parameter int HIGH_WATER = 500
) (
   input  logic clk,
   input  logic reset,
   input  logic Start,
   input  logic [9:0] no_of_input_layers,
   input  logic [9:0] input_layer_row_size,
   input  logic [9:0] input_layer_col_size,
   input  logic signed [ACC_WIDTH-1:0] bias,
   input  logic [4:0] shift_amt,
   input  logic relu_en,
   output logic busy,
   output logic done,
   output_requant_if.slave bus
);
   import output_requant_pkg::*;
   logic [1:0] state_q, state_d;
   dims_t dims_q, dims_d;
   logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
   logic [4:0] shift_q, shift_d;
   logic relu_q, relu_d;
   logic [9:0] col_q, col_d, row_q, row_d, lay_q, lay_d;
   logic [PIPE_DEPTH-1:0] vld;
   logic [1:0] inflight;
   logic [FIFO_COUNT_WIDTH:0] occ;
   logic start, xfer, last_col, last_row, last_lay;
   // in-flight words count against the FIFO so every accepted word has room when it lands
   always_comb begin
      inflight = 2'($countones(vld));
      occ = (FIFO_COUNT_WIDTH+1)'(bus.fifo_dcount) + (FIFO_COUNT_WIDTH+1)'(inflight);
      bus.acc_ready = state_q == S_RUN && occ < (FIFO_COUNT_WIDTH+1)'(HIGH_WATER);
      xfer = bus.acc_valid && bus.acc_ready;
      start = state_q == S_IDLE && Start;
      last_col = col_q == dims_q.cols - 10'd1;
      last_row = row_q == dims_q.rows - 10'd1;
      last_lay = lay_q == dims_q.layers - 10'd1;
      dims_d = start ? dims_t'{no_of_input_layers, input_layer_row_size, input_layer_col_size} : dims_q;
      bias_d = start ? bias : bias_q;
      shift_d = start ? shift_amt : shift_q;
      relu_d = start ? relu_en : relu_q;
      col_d = start ? '0 : xfer ? (last_col ? '0 : col_q + 10'd1) : col_q;
      row_d = start ? '0 : xfer && last_col ? (last_row ? '0 : row_q + 10'd1) : row_q;
      lay_d = start ? '0 : xfer && last_col && last_row ? (last_lay ? '0 : lay_q + 10'd1) : lay_q;
      state_d = start ? S_RUN
              : state_q == S_RUN && xfer && last_col && last_row && last_lay ? S_DRAIN
              : state_q == S_DRAIN && inflight == 2'd0 ? S_DONE
              : state_q == S_DONE ? S_IDLE : state_q;
      busy = state_q == S_RUN || state_q == S_DRAIN;
      done = state_q == S_DONE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         dims_q <= '0;
         bias_q <= '0;
         shift_q <= '0;
         relu_q <= 1'b0;
         col_q <= '0;
         row_q <= '0;
         lay_q <= '0;
      end else begin
         state_q <= state_d;
         dims_q <= dims_d;
         bias_q <= bias_d;
         shift_q <= shift_d;
         relu_q <= relu_d;
         col_q <= col_d;
         row_q <= row_d;
         lay_q <= lay_d;
      end
   end
   requant_pipe #(.ACC_WIDTH(ACC_WIDTH), .DATA_W(STREAM_DATA_WIDTH)) u_pipe (
      .clk(clk),
      .reset(reset),
      .in_valid_i(xfer),
      .acc_i(bus.acc_data),
      .bias_i(bias_q),
      .shift_i(shift_q),
      .relu_i(relu_q),
      .vld_o(vld),
      .dout_o(bus.fifo_din)
   );
   assign bus.fifo_wr_en = vld[PIPE_DEPTH-1];
endmodule

// File: tb/tb_output_requant.sv
// tb_output_requant: scoreboard bench; expected pixels are queued at acceptance and
// matched against FIFO writes, including value and 3-cycle latency.
module tb_output_requant;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic Start = 1'b0;
   logic [9:0] layers = 10'd1, rows = 10'd1, cols = 10'd1;
   logic signed [31:0] bias = '0;
   logic [4:0] shift_amt = '0;
   logic relu_en = 1'b0;
   logic busy, done;
   output_requant_if #(.ACC_WIDTH(32), .STREAM_DATA_WIDTH(8), .FIFO_COUNT_WIDTH(10)) bus ();
   output_requant #(.ACC_WIDTH(32), .STREAM_DATA_WIDTH(8), .FIFO_COUNT_WIDTH(10), .HIGH_WATER(500)) dut (
      .clk(clk),
      .reset(reset),
      .Start(Start),
      .no_of_input_layers(layers),
      .input_layer_row_size(rows),
      .input_layer_col_size(cols),
      .bias(bias),
      .shift_amt(shift_amt),
      .relu_en(relu_en),
      .busy(busy),
      .done(done),
      .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0] v;
      int c;
   } exp_t;
   exp_t sb[$];
   logic [7:0] wr_log[$];
   int cyc = 0, vectors = 0, miscompares = 0, wr_count = 0, last_wr_cyc = 0, set_base = 0;
   logic signed [31:0] m_bias = '0;
   int m_shift = 0;
   bit m_relu = 1'b0;
   task automatic check(input string tag, input longint got, input longint exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] model(input longint a, input longint b, input int sh, input bit relu);
      longint s;
      s = a + b;
      if (sh != 0) s = s + (longint'(1) <<< (sh - 1));
      s = s >>> sh;
      if (relu) begin
         if (s < 0) return 8'd0;
         if (s > 255) return 8'd255;
      end else begin
         if (s < -128) return 8'h80;
         if (s > 127) return 8'h7f;
      end
      return 8'(s);
   endfunction
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         sb.delete();
         check("wr_in_reset", bus.fifo_wr_en, 0);
      end else begin
         if (bus.acc_valid) check("ready_flow", bus.acc_ready, longint'((int'(bus.fifo_dcount) + sb.size()) < 500));
         if (bus.fifo_wr_en) begin
            if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
            else begin
               e = sb.pop_front();
               check("din", bus.fifo_din, e.v);
               check("latency", cyc - e.c, 3);
            end
            wr_count++;
            wr_log.push_back(bus.fifo_din);
            last_wr_cyc = cyc;
         end
         if (bus.acc_valid && bus.acc_ready) sb.push_back('{model(bus.acc_data, m_bias, m_shift, m_relu), cyc});
      end
   end
   task automatic start_set(input int l, input int r, input int c, input logic signed [31:0] b, input int s, input bit rl);
      layers = 10'(l);
      rows = 10'(r);
      cols = 10'(c);
      bias = b;
      shift_amt = 5'(s);
      relu_en = rl;
      m_bias = b;
      m_shift = s;
      m_relu = rl;
      set_base = wr_count;
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      check("busy_run", busy, 1);
   endtask
   task automatic send(input logic signed [31:0] a);
      int n = 0;
      bus.acc_data = a;
      bus.acc_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.acc_ready && n < 200);
      if (!bus.acc_ready) check("send_timeout", bus.acc_ready, 1);
      @(posedge clk);
      #1 bus.acc_valid = 1'b0;
   endtask
   task automatic finish_set(input int n);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 400);
      check("done_seen", done, 1);
      check("done_lat", cyc - last_wr_cyc, 2);
      check("writes", wr_count - set_base, n);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
      check("sb_empty", sb.size(), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.acc_valid = 1'b0;
      bus.acc_data = '0;
      bus.fifo_dcount = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", bus.acc_ready, 0);
      check("rst_wr_en", bus.fifo_wr_en, 0);
      check("rst_din", bus.fifo_din, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      // ReLU with rounding: -50, 3, 1000 -> 0, 3, 253
      start_set(1, 1, 3, 10, 2, 1'b1);
      send(-50);
      send(3);
      send(1000);
      finish_set(3);
      check("relu_w0", wr_log[set_base], 0);
      check("relu_w1", wr_log[set_base+1], 3);
      check("relu_w2", wr_log[set_base+2], 253);
      // signed saturation: 200, -300, -1 -> 127, 0x80, 0xFF
      start_set(1, 1, 3, 0, 0, 1'b0);
      send(200);
      send(-300);
      send(-1);
      finish_set(3);
      check("sat_w0", wr_log[set_base], 8'h7f);
      check("sat_w1", wr_log[set_base+1], 8'h80);
      check("sat_w2", wr_log[set_base+2], 8'hff);
      // 1x1x1 set
      start_set(1, 1, 1, -7, 1, 1'b0);
      send(20);
      finish_set(1);
      check("one_w0", wr_log[set_base], 7);
      // 2x3x4 streaming with random config and data
      start_set(2, 3, 4, $urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 24; i++) send($urandom);
      @(negedge clk);
      check("ready_drop", bus.acc_ready, 0);
      finish_set(24);
      // high-water throttling then release
      start_set(1, 1, 8, 3, 3, 1'b0);
      bus.fifo_dcount = 10'd498;
      for (int i = 0; i < 4; i++) send($urandom_range(0, 4000) - 2000);
      bus.fifo_dcount = 10'd0;
      for (int i = 0; i < 4; i++) send($urandom_range(0, 4000) - 2000);
      finish_set(8);
      // reset while a word is in flight
      start_set(1, 1, 4, 0, 0, 1'b0);
      send(37);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_busy", busy, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_no_wr", wr_count - set_base, 0);
      start_set(1, 1, 2, -5, 1, 1'b0);
      send(21);
      send(-100);
      finish_set(2);
      check("fresh_w0", wr_log[set_base], 8);
      check("fresh_w1", wr_log[set_base+1], 8'hcc);
      // Start pulsed mid-run must be ignored
      start_set(1, 2, 3, 100, 4, 1'b1);
      send(500);
      send(-900);
      layers = 10'd5;
      cols = 10'd1;
      relu_en = 1'b0;
      bias = 32'sd0;
      Start = 1'b1;
      @(posedge clk);
      #1 Start = 1'b0;
      check("busy_ign", busy, 1);
      for (int i = 0; i < 4; i++) send($urandom_range(0, 8000) - 4000);
      finish_set(6);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/output_requant.md
OUTPUT_REQUANT -- requirements
Module: output_requant

Interface
REQ-001 Parameter ACC_WIDTH, default 32: signed accumulator input width.
REQ-002 Parameter STREAM_DATA_WIDTH, default 8: output pixel width written to the output FIFO.
REQ-003 Parameter FIFO_COUNT_WIDTH, default 10: width of the FIFO data_count input.
REQ-004 Parameter HIGH_WATER, default 500: FIFO occupancy limit, counting in-flight words.
REQ-005 Ports SHALL be:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
Start  in  1  one-cycle pulse; latches configuration and begins a layer set.
no_of_input_layers  in  10  number of layers in the set, >=1.
input_layer_row_size  in  10  rows per layer, >=1.
input_layer_col_size  in  10  columns per layer, >=1.
bias  in  ACC_WIDTH  signed bias, latched at Start.
shift_amt  in  5  arithmetic right shift, latched at Start.
relu_en  in  1  1 = ReLU, unsigned clamp; latched at Start.
acc_data  in  ACC_WIDTH  signed accumulator value.
acc_valid  in  1  acc_data valid.
acc_ready  out  1  block accepts acc_data this cycle.
fifo_din  out  STREAM_DATA_WIDTH  pixel to the output FIFO.
fifo_wr_en  out  1  write strobe to the output FIFO.
fifo_dcount  in  FIFO_COUNT_WIDTH  output FIFO occupancy.
busy  out  1  high from the cycle after Start until done.
done  out  1  one-cycle pulse after the last pixel is written.

Function
REQ-006 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-007 IDLE->RUN on Start; configuration registered on that edge; Start ignored outside IDLE.
REQ-008 A transfer occurs on acc_valid && acc_ready; acc_ready is 0 outside RUN.
REQ-009 In RUN, acc_ready = (fifo_dcount + inflight) < HIGH_WATER; inflight = valid pipeline stages (0..3).
REQ-010 Stage 1: sum = acc_data + bias at ACC_WIDTH+1 bits, no overflow.
REQ-011 Stage 2: rounded = (sum + (shift_amt ? 1<<(shift_amt-1) : 0)) >>> shift_amt, arithmetic shift, round half up.
REQ-012 Stage 3, relu_en=1: clamp rounded to [0,255].
REQ-013 Stage 3, relu_en=0: clamp rounded to [-128,127]; emit as two's complement.
REQ-014 Latency: fifo_wr_en asserts exactly 3 cycles after the accepting edge; one write per transfer; order preserved; no bubbles are inserted.
REQ-015 Column, row and layer counters advance per transfer; col wraps at col_size-1 and increments row; row wraps at row_size-1 and increments layer.
REQ-016 On acceptance of the last element (last col, row and layer): RUN->DRAIN; acc_ready drops the next cycle.
REQ-017 DRAIN->DONE when the pipeline is empty; DONE->IDLE after one cycle; done = 1 only in DONE.
REQ-018 A 1x1x1 set SHALL complete with exactly one write.
REQ-019 fifo_dcount at or above HIGH_WATER with inflight>0: pipeline still completes; the writes are not stalled, and headroom is guaranteed by HIGH_WATER < FIFO depth - 3.

Reset
REQ-020 Reset SHALL force: state IDLE, counters 0, pipeline valids 0, acc_ready 0, fifo_wr_en 0, fifo_din 0, busy 0, done 0.
REQ-021 Reset mid-RUN/DRAIN SHALL discard in-flight data; no FIFO write on the reset or following cycle.

Structure
REQ-022 Shared package holds FSM state encoding, STREAM_DATA_WIDTH, the pipeline depth constant (3) and the clamp limits.
REQ-023 The arithmetic (bias/round-shift/clamp) SHALL be one sub-module, requant_pipe; output_requant holds the FSM, counters and flow control.

Verification
REQ-024 relu_en=1, bias=10, shift=2, acc=-50, 3, 1000 -> fifo_din 0, 3, 253; each write 3 cycles after its acceptance.
REQ-025 relu_en=0, bias=0, shift=0, acc=200, -300, -1 -> 127, 0x80, 0xFF.
REQ-026 layers=2, rows=3, cols=4, acc_valid held high, fifo_dcount=0 -> exactly 24 writes, done one cycle after pipeline empties, busy low after.
REQ-027 fifo_dcount held at 498 -> acc_ready high only while inflight<2; releasing to 0 resumes streaming; no data lost.
REQ-028 Reset asserted 2 cycles after a transfer -> no fifo_wr_en; a new Start yields correct fresh output.
REQ-029 Start pulsed during RUN -> ignored; element count and done timing unchanged.
